// File: rtl/instr_fetch.sv
// Dual-issue instruction fetch: holds the PC, reads two consecutive words per cycle
// from a preloaded private instruction memory, and redirects on taken branches.
module instr_fetch #(
  parameter int unsigned IM_DEPTH = 1024,
  parameter logic [0:9]  START_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [0:9]  new_PC,
  input  logic        preload_IM_en,
  input  logic [0:9]  preload_IM_addr,
  input  logic [0:31] preload_IM_data,
  output logic [0:31] instr0,
  output logic [0:31] instr1,
  output logic [0:9]  fetch_PC,
  output logic [0:1]  instr_valid,
  output logic        flush,
  output logic        halted
);

  localparam int unsigned PC_W   = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned STOP_W = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  logic [0:PC_W-1]    r_pc;
  logic [0:WORD_W-1]  r_mem [0:IM_DEPTH-1];

  logic [0:PC_W-1]    w_pc_p1;
  logic [0:PC_W-1]    w_pc_p2;
  logic [0:WORD_W-1]  w_word0;
  logic [0:WORD_W-1]  w_word1;
  logic               w_stop0;
  logic               w_stop1;

  // Preload write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (preload_IM_en) begin
      r_mem[preload_IM_addr] <= preload_IM_data;
    end
  end

  // Combinational pair read; PC arithmetic wraps modulo the 10-bit span.
  assign w_pc_p1 = PC_W'(r_pc + PC_W'(1));
  assign w_pc_p2 = PC_W'(r_pc + PC_W'(2));
  assign w_word0 = r_mem[r_pc];
  assign w_word1 = r_mem[w_pc_p1];
  assign w_stop0 = (w_word0[0:STOP_W-1] == STOP_W'(0));
  assign w_stop1 = (w_word1[0:STOP_W-1] == STOP_W'(0));

  assign flush  = is_branch & branch_taken;
  assign halted = (r_state == S_HALT);

  // Fetch FSM: a taken branch outranks stall and stop detection in RUN and HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= START_PC;
      instr0      <= '0;
      instr1      <= '0;
      fetch_PC    <= '0;
      instr_valid <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          instr_valid <= 2'b00;
          if (start) begin
            r_state <= S_RUN;
            r_pc    <= START_PC;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_pc        <= new_PC;
            instr_valid <= 2'b00;
          end else if (!stall) begin
            instr0   <= w_word0;
            instr1   <= w_word1;
            fetch_PC <= r_pc;
            r_pc     <= w_pc_p2;
            if (w_stop0) begin
              instr_valid <= 2'b10;
              r_state     <= S_HALT;
            end else if (w_stop1) begin
              instr_valid <= 2'b11;
              r_state     <= S_HALT;
            end else begin
              instr_valid <= 2'b11;
            end
          end
        end
        S_HALT: begin
          instr_valid <= 2'b00;
          // The stop was on the wrong path; resume at the branch target.
          if (flush) begin
            r_pc    <= new_PC;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          instr_valid <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one DUT at START_PC=0, one at START_PC=1022.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        start_a;
  logic        start_b;
  logic        stall;
  logic        is_branch;
  logic        branch_taken;
  logic [0:9]  new_PC;
  logic        preload_IM_en;
  logic [0:9]  preload_IM_addr;
  logic [0:31] preload_IM_data;

  logic [0:31] a_instr0, a_instr1, b_instr0, b_instr1;
  logic [0:9]  a_fetch_PC, b_fetch_PC;
  logic [0:1]  a_valid, b_valid;
  logic        a_flush, b_flush, a_halted, b_halted;

  int pass_cnt;
  int total_cnt;

  instr_fetch #(.IM_DEPTH(1024), .START_PC(10'd0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stall(stall),
    .is_branch(is_branch), .branch_taken(branch_taken), .new_PC(new_PC),
    .preload_IM_en(preload_IM_en), .preload_IM_addr(preload_IM_addr),
    .preload_IM_data(preload_IM_data),
    .instr0(a_instr0), .instr1(a_instr1), .fetch_PC(a_fetch_PC),
    .instr_valid(a_valid), .flush(a_flush), .halted(a_halted)
  );

  instr_fetch #(.IM_DEPTH(1024), .START_PC(10'd1022)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stall(stall),
    .is_branch(is_branch), .branch_taken(branch_taken), .new_PC(new_PC),
    .preload_IM_en(preload_IM_en), .preload_IM_addr(preload_IM_addr),
    .preload_IM_data(preload_IM_data),
    .instr0(b_instr0), .instr1(b_instr1), .fetch_PC(b_fetch_PC),
    .instr_valid(b_valid), .flush(b_flush), .halted(b_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [0:9] addr, input logic [0:31] data);
    preload_IM_en   = 1'b1;
    preload_IM_addr = addr;
    preload_IM_data = data;
    step();
    preload_IM_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total_cnt++; if (a_instr0 !== 32'h0) $display("FAIL reset_instr0 got %h exp 0", a_instr0); else pass_cnt++;
    total_cnt++; if (a_instr1 !== 32'h0) $display("FAIL reset_instr1 got %h exp 0", a_instr1); else pass_cnt++;
    total_cnt++; if (a_fetch_PC !== 10'd0) $display("FAIL reset_fetch_pc got %0d exp 0", a_fetch_PC); else pass_cnt++;
    total_cnt++; if (a_valid !== 2'b00) $display("FAIL reset_valid got %b exp 00", a_valid); else pass_cnt++;
    total_cnt++; if (a_halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", a_halted); else pass_cnt++;
    rst = 1'b0;
    // Taken branch in IDLE is ignored apart from the combinational flush.
    is_branch = 1'b1; branch_taken = 1'b1; new_PC = 10'd300;
    #1;
    total_cnt++; if (a_flush !== 1'b1) $display("FAIL idle_flush_comb got %b exp 1", a_flush); else pass_cnt++;
    step();
    is_branch = 1'b0; branch_taken = 1'b0;
    total_cnt++; if (a_valid !== 2'b00 || a_halted !== 1'b0) $display("FAIL idle_flush_ignored valid %b halted %b exp 00/0", a_valid, a_halted); else pass_cnt++;
  endtask

  task automatic test_sequential();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    total_cnt++; if (a_valid !== 2'b00) $display("FAIL start_latency valid got %b exp 00", a_valid); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      logic [0:9]  exp_pc;
      logic [0:31] exp0;
      logic [0:31] exp1;
      exp_pc = 10'(2 * k);
      exp0   = 32'h1000_0000 + 32'(exp_pc);
      exp1   = exp0 + 32'd1;
      step();
      total_cnt++; if (a_fetch_PC !== exp_pc) $display("FAIL seq_pc[%0d] got %0d exp %0d", k, a_fetch_PC, exp_pc); else pass_cnt++;
      total_cnt++; if (a_instr0 !== exp0 || a_instr1 !== exp1) $display("FAIL seq_words[%0d] got %h/%h exp %h/%h", k, a_instr0, a_instr1, exp0, exp1); else pass_cnt++;
      total_cnt++; if (a_valid !== 2'b11) $display("FAIL seq_valid[%0d] got %b exp 11", k, a_valid); else pass_cnt++;
    end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1;
    step();
    total_cnt++; if (a_fetch_PC !== 10'd6 || a_valid !== 2'b11) $display("FAIL stall_hold pc %0d valid %b exp 6/11", a_fetch_PC, a_valid); else pass_cnt++;
    is_branch = 1'b1; branch_taken = 1'b0; new_PC = 10'd100;
    #1;
    total_cnt++; if (a_flush !== 1'b0) $display("FAIL not_taken_flush got %b exp 0", a_flush); else pass_cnt++;
    step();
    total_cnt++; if (a_fetch_PC !== 10'd6 || a_valid !== 2'b11 || a_instr0 !== 32'h1000_0006) $display("FAIL not_taken_hold pc %0d valid %b i0 %h exp 6/11/10000006", a_fetch_PC, a_valid, a_instr0); else pass_cnt++;
    branch_taken = 1'b1;
    #1;
    total_cnt++; if (a_flush !== 1'b1) $display("FAIL taken_flush got %b exp 1", a_flush); else pass_cnt++;
    step();
    is_branch = 1'b0; branch_taken = 1'b0;
    total_cnt++; if (a_valid !== 2'b00) $display("FAIL flush_bubble valid got %b exp 00", a_valid); else pass_cnt++;
    stall = 1'b0;
    step();
    total_cnt++; if (a_fetch_PC !== 10'd100 || a_valid !== 2'b11) $display("FAIL redirect pc %0d valid %b exp 100/11", a_fetch_PC, a_valid); else pass_cnt++;
    total_cnt++; if (a_instr0 !== 32'h1000_0064 || a_instr1 !== 32'h1000_0065) $display("FAIL redirect_words got %h/%h exp 10000064/10000065", a_instr0, a_instr1); else pass_cnt++;
  endtask

  task automatic test_stop_slot0();
    do_reset();
    preload(10'd4, 32'h0000_0000);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    total_cnt++; if (a_fetch_PC !== 10'd4 || a_valid !== 2'b10) $display("FAIL stop0_pair pc %0d valid %b exp 4/10", a_fetch_PC, a_valid); else pass_cnt++;
    total_cnt++; if (a_instr0 !== 32'h0 || a_instr1 !== 32'h1000_0005) $display("FAIL stop0_words got %h/%h exp 0/10000005", a_instr0, a_instr1); else pass_cnt++;
    total_cnt++; if (a_halted !== 1'b1) $display("FAIL stop0_halted got %b exp 1", a_halted); else pass_cnt++;
    step();
    total_cnt++; if (a_valid !== 2'b00 || a_halted !== 1'b1) $display("FAIL stop0_after valid %b halted %b exp 00/1", a_valid, a_halted); else pass_cnt++;
  endtask

  task automatic test_resume();
    is_branch = 1'b1; branch_taken = 1'b1; new_PC = 10'd20;
    step();
    is_branch = 1'b0; branch_taken = 1'b0;
    total_cnt++; if (a_halted !== 1'b0 || a_valid !== 2'b00) $display("FAIL resume_bubble halted %b valid %b exp 0/00", a_halted, a_valid); else pass_cnt++;
    step();
    total_cnt++; if (a_fetch_PC !== 10'd20 || a_valid !== 2'b11 || a_instr0 !== 32'h1000_0014) $display("FAIL resume_fetch pc %0d valid %b i0 %h exp 20/11/10000014", a_fetch_PC, a_valid, a_instr0); else pass_cnt++;
  endtask

  task automatic test_stop_slot1();
    do_reset();
    preload(10'd4, 32'h1000_0004);
    preload(10'd5, 32'h0000_0000);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    total_cnt++; if (a_fetch_PC !== 10'd4 || a_valid !== 2'b11) $display("FAIL stop1_pair pc %0d valid %b exp 4/11", a_fetch_PC, a_valid); else pass_cnt++;
    total_cnt++; if (a_instr1 !== 32'h0 || a_halted !== 1'b1) $display("FAIL stop1_halt i1 %h halted %b exp 0/1", a_instr1, a_halted); else pass_cnt++;
    step();
    total_cnt++; if (a_valid !== 2'b00) $display("FAIL stop1_after valid got %b exp 00", a_valid); else pass_cnt++;
    preload(10'd5, 32'h1000_0005);
  endtask

  task automatic test_wrap();
    do_reset();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    total_cnt++; if (b_fetch_PC !== 10'd1022 || b_instr0 !== 32'h1000_03FE || b_instr1 !== 32'h1000_03FF) $display("FAIL wrap_first pc %0d got %h/%h exp 1022 100003fe/100003ff", b_fetch_PC, b_instr0, b_instr1); else pass_cnt++;
    step();
    total_cnt++; if (b_fetch_PC !== 10'd0 || b_instr0 !== 32'h1000_0000) $display("FAIL wrap_next pc %0d i0 %h exp 0/10000000", b_fetch_PC, b_instr0); else pass_cnt++;
    is_branch = 1'b1; branch_taken = 1'b1; new_PC = 10'd1023;
    step();
    is_branch = 1'b0; branch_taken = 1'b0;
    step();
    total_cnt++; if (b_fetch_PC !== 10'd1023 || b_instr0 !== 32'h1000_03FF || b_instr1 !== 32'h1000_0000) $display("FAIL wrap_odd pc %0d got %h/%h exp 1023 100003ff/10000000", b_fetch_PC, b_instr0, b_instr1); else pass_cnt++;
    step();
    total_cnt++; if (b_fetch_PC !== 10'd1 || b_valid !== 2'b11) $display("FAIL wrap_odd_next pc %0d valid %b exp 1/11", b_fetch_PC, b_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (b_instr0 !== 32'h0 || b_instr1 !== 32'h0) $display("FAIL async_rst_words got %h/%h exp 0/0", b_instr0, b_instr1); else pass_cnt++;
    total_cnt++; if (b_fetch_PC !== 10'd0 || b_valid !== 2'b00 || b_halted !== 1'b0) $display("FAIL async_rst_ctrl pc %0d valid %b halted %b exp 0/00/0", b_fetch_PC, b_valid, b_halted); else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    total_cnt++; if (b_valid !== 2'b00) $display("FAIL async_rst_idle valid got %b exp 00", b_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    rst             = 1'b1;
    start_a         = 1'b0;
    start_b         = 1'b0;
    stall           = 1'b0;
    is_branch       = 1'b0;
    branch_taken    = 1'b0;
    new_PC          = 10'd0;
    preload_IM_en   = 1'b0;
    preload_IM_addr = 10'd0;
    preload_IM_data = 32'd0;
    test_reset();
    for (int k = 0; k < 1024; k++) begin
      preload(10'(k), 32'h1000_0000 + 32'(k));
    end
    test_sequential();
    test_branch_stall();
    test_stop_slot0();
    test_resume();
    test_stop_slot1();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
